pu_shared_mem_arb: RTL

PU_SHARED_MEM_ARB -- requirements
Module: pu_shared_mem_arb

---
 rtl/pu_shared_mem_arb_pkg.sv | 36 +++
 rtl/pu_shared_mem_arb_rr_arb_n.sv | 47 ++++
 rtl/pu_shared_mem_arb.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/pu_shared_mem_arb_pkg.sv
// Shared types for the PU shared-memory arbiter: PU command format, memory
// region map and the helper that forms a RAM word index from a command.
package pu_shared_mem_arb_pkg;

  localparam int IO_ADDR_W  = 16;
  localparam int IO_FID_W   = 8;
  localparam int IO_DATA_W  = 32;
  localparam int REGION_MSB = 15;
  localparam int REGION_LSB = 12;
  localparam int REGION_W   = REGION_MSB - REGION_LSB + 1;
  localparam int MEM_IDX_W  = IO_FID_W + REGION_LSB;

  // Top nibble of io_type.addr selects which memory instance owns the access.
  typedef enum logic [REGION_W-1:0] {
    PU_FLOW_MEM  = 4'h0,
    PU_STATS_MEM = 4'h1,
    PU_CFG_MEM   = 4'h2,
    PU_PKT_MEM   = 4'h3
  } mem_region_e;

  typedef struct packed {
    logic                 wr;
    logic [IO_ADDR_W-1:0] addr;
    logic [IO_FID_W-1:0]  fid;
    logic [IO_DATA_W-1:0] wdata;
  } io_type;

  // Full word index {fid, in-region offset}; each instance keeps its low bits.
  function automatic logic [MEM_IDX_W-1:0] mem_index(
    input logic [IO_FID_W-1:0]   fid,
    input logic [REGION_LSB-1:0] low
  );
    return {fid, low};
  endfunction

endpackage

// File: rtl/pu_shared_mem_arb_rr_arb_n.sv
// Round-robin arbiter over NUM_OF_PU requesters: one grant per cycle, search
// starts at the pointer, pointer moves to the granted index + 1.
module rr_arb_n
  import pu_shared_mem_arb_pkg::*;
#(
  parameter int NUM_OF_PU = 16,
  parameter int SEL_W     = $clog2(NUM_OF_PU)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_OF_PU-1:0] req,
  output logic [NUM_OF_PU-1:0] ack,
  output logic [SEL_W-1:0]     sel,
  output logic                 gnt
);

  localparam logic [SEL_W:0]   N_L  = (SEL_W + 1)'(NUM_OF_PU);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_OF_PU - 1);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W:0]   cand;

  always_comb begin
    ack  = '0;
    sel  = '0;
    gnt  = 1'b0;
    cand = '0;
    for (int k = 0; k < NUM_OF_PU; k++) begin
      cand = {1'b0, ptr} + (SEL_W + 1)'(k);
      if (cand >= N_L) cand = cand - N_L;
      if (!gnt && req[cand]) begin
        gnt = 1'b1;
        sel = cand[SEL_W-1:0];
      end
    end
    if (gnt) ack[sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (gnt) begin
      ptr <= (sel == LAST) ? '0 : sel + 1'b1;
    end
  end

endmodule

// File: rtl/pu_shared_mem_arb.sv
// Shared 1R1W memory for NUM_OF_PU processing units: per-PU command queues,
// independent read and write round-robin arbiters, fixed-latency acks.
module pu_shared_mem_arb
  import pu_shared_mem_arb_pkg::*;
#(
  parameter int          NUM_OF_PU   = 16,
  parameter int          WIDTH_NBITS = 32,
  parameter int          DEPTH_NBITS = 12,
  parameter int          FIFO_DEPTH  = 4,
  parameter int          RD_LAT      = 1,
  parameter mem_region_e MEM_SEL     = PU_FLOW_MEM
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_OF_PU-1:0]                  io_req,
  input  io_type [NUM_OF_PU-1:0]                io_cmd,
  output logic [NUM_OF_PU-1:0]                  io_rdy,
  output logic [NUM_OF_PU-1:0]                  io_ack,
  output logic [NUM_OF_PU-1:0][WIDTH_NBITS-1:0] io_ack_data,
  output logic [NUM_OF_PU-1:0]                  err_ovf
);

  localparam int SEL_W     = $clog2(NUM_OF_PU);
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int ENT_W     = 1 + DEPTH_NBITS + WIDTH_NBITS;
  localparam int ADDR_HI   = DEPTH_NBITS + WIDTH_NBITS - 1;
  localparam int RAM_WORDS = 1 << DEPTH_NBITS;

  function automatic logic [NUM_OF_PU-1:0] pu_onehot(input logic [SEL_W-1:0] idx);
    pu_onehot      = '0;
    pu_onehot[idx] = 1'b1;
  endfunction

  // Decode and enqueue
  logic [NUM_OF_PU-1:0]                hit;
  logic [NUM_OF_PU-1:0]                push;
  logic [NUM_OF_PU-1:0]                pop;
  logic [NUM_OF_PU-1:0][MEM_IDX_W-1:0] cmd_idx;
  logic [ENT_W-1:0]                    cmd_ent [NUM_OF_PU];
  logic                                unused_cmd_bits;

  logic [ENT_W-1:0] q_mem  [NUM_OF_PU][FIFO_DEPTH];
  logic [ENT_W-1:0] q_head [NUM_OF_PU];
  logic [PTR_W-1:0] q_wptr [NUM_OF_PU];
  logic [PTR_W-1:0] q_rptr [NUM_OF_PU];
  logic [CNT_W-1:0] q_cnt  [NUM_OF_PU];

  // Only the low DEPTH_NBITS of the word index address this instance.
  assign unused_cmd_bits = ^{cmd_idx, io_cmd};

  always_comb begin
    io_rdy = '0;
    for (int i = 0; i < NUM_OF_PU; i++) begin
      io_rdy[i] = (q_cnt[i] != CNT_W'(FIFO_DEPTH));
    end
  end

  always_comb begin
    hit     = '0;
    push    = '0;
    cmd_idx = '0;
    for (int i = 0; i < NUM_OF_PU; i++) begin
      hit[i]     = io_req[i] &&
                   (io_cmd[i].addr[REGION_MSB:REGION_LSB] == REGION_W'(MEM_SEL));
      push[i]    = hit[i] && io_rdy[i];
      cmd_idx[i] = mem_index(io_cmd[i].fid, io_cmd[i].addr[REGION_LSB-1:0]);
      cmd_ent[i] = {io_cmd[i].wr, cmd_idx[i][DEPTH_NBITS-1:0],
                    io_cmd[i].wdata[WIDTH_NBITS-1:0]};
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_OF_PU; i++) begin
      if (push[i]) q_mem[i][q_wptr[i]] <= cmd_ent[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_OF_PU; i++) begin
      if (!rst_n) begin
        q_wptr[i] <= '0;
        q_rptr[i] <= '0;
        q_cnt[i]  <= '0;
      end else begin
        if (push[i]) q_wptr[i] <= q_wptr[i] + 1'b1;
        if (pop[i])  q_rptr[i] <= q_rptr[i] + 1'b1;
        if (push[i] && !pop[i])      q_cnt[i] <= q_cnt[i] + 1'b1;
        else if (!push[i] && pop[i]) q_cnt[i] <= q_cnt[i] - 1'b1;
      end
    end
  end

  // Overflow is sticky: a decoded request against a full queue is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) err_ovf <= '0;
    else        err_ovf <= err_ovf | (hit & ~io_rdy);
  end

  // Arbitrate queue heads (p0: grant, RAM write, RAM read address)
  logic [NUM_OF_PU-1:0] rd_req, wr_req, rd_ack, wr_ack;
  logic [SEL_W-1:0]     rd_sel, wr_sel;
  logic                 rd_gnt, wr_gnt;

  always_comb begin
    rd_req = '0;
    wr_req = '0;
    for (int i = 0; i < NUM_OF_PU; i++) begin
      q_head[i] = q_mem[i][q_rptr[i]];
      rd_req[i] = rst_n && (q_cnt[i] != '0) && !q_head[i][ENT_W-1];
      wr_req[i] = rst_n && (q_cnt[i] != '0) &&  q_head[i][ENT_W-1];
    end
  end

  rr_arb_n #(.NUM_OF_PU(NUM_OF_PU), .SEL_W(SEL_W)) u_rd_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (rd_req),
    .ack   (rd_ack),
    .sel   (rd_sel),
    .gnt   (rd_gnt)
  );

  rr_arb_n #(.NUM_OF_PU(NUM_OF_PU), .SEL_W(SEL_W)) u_wr_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (wr_req),
    .ack   (wr_ack),
    .sel   (wr_sel),
    .gnt   (wr_gnt)
  );

  // A PU's head is either a read or a write, so at most one pop per PU.
  assign pop = rd_ack | wr_ack;

  logic [DEPTH_NBITS-1:0] waddr_p0, raddr_p0;
  logic [WIDTH_NBITS-1:0] wdata_p0;
  logic [WIDTH_NBITS-1:0] ram [RAM_WORDS];

  assign waddr_p0 = q_head[wr_sel][ADDR_HI -: DEPTH_NBITS];
  assign wdata_p0 = q_head[wr_sel][WIDTH_NBITS-1:0];
  assign raddr_p0 = q_head[rd_sel][ADDR_HI -: DEPTH_NBITS];

  always_ff @(posedge clk) begin
    if (wr_gnt) ram[waddr_p0] <= wdata_p0;
  end

  // p1: registered RAM read, write-first bypass on a same-cycle collision
  logic                   rd_vld_p1, wr_vld_p1;
  logic [SEL_W-1:0]       rd_pu_p1, wr_pu_p1;
  logic [WIDTH_NBITS-1:0] rd_data_p1;

  always_ff @(posedge clk) begin
    rd_data_p1 <= (wr_gnt && (waddr_p0 == raddr_p0)) ? wdata_p0 : ram[raddr_p0];
    rd_pu_p1   <= rd_sel;
    wr_pu_p1   <= wr_sel;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_vld_p1 <= 1'b0;
      wr_vld_p1 <= 1'b0;
    end else begin
      rd_vld_p1 <= rd_gnt;
      wr_vld_p1 <= wr_gnt;
    end
  end

  // p2: optional RAM output register; writes ride along to keep ack order
  logic                   rd_vld_pf, wr_vld_pf;
  logic [SEL_W-1:0]       rd_pu_pf, wr_pu_pf;
  logic [WIDTH_NBITS-1:0] rd_data_pf;

  if (RD_LAT == 2) begin : g_lat2
    logic                   rd_vld_p2, wr_vld_p2;
    logic [SEL_W-1:0]       rd_pu_p2, wr_pu_p2;
    logic [WIDTH_NBITS-1:0] rd_data_p2;

    always_ff @(posedge clk) begin
      rd_data_p2 <= rd_data_p1;
      rd_pu_p2   <= rd_pu_p1;
      wr_pu_p2   <= wr_pu_p1;
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rd_vld_p2 <= 1'b0;
        wr_vld_p2 <= 1'b0;
      end else begin
        rd_vld_p2 <= rd_vld_p1;
        wr_vld_p2 <= wr_vld_p1;
      end
    end

    assign rd_vld_pf  = rd_vld_p2;
    assign wr_vld_pf  = wr_vld_p2;
    assign rd_pu_pf   = rd_pu_p2;
    assign wr_pu_pf   = wr_pu_p2;
    assign rd_data_pf = rd_data_p2;
  end else begin : g_lat1
    assign rd_vld_pf  = rd_vld_p1;
    assign wr_vld_pf  = wr_vld_p1;
    assign rd_pu_pf   = rd_pu_p1;
    assign wr_pu_pf   = wr_pu_p1;
    assign rd_data_pf = rd_data_p1;
  end

  // Ack output register: RD_LAT+1 cycles after grant
  logic [NUM_OF_PU-1:0]   rd_ack_q, wr_ack_q;
  logic [WIDTH_NBITS-1:0] ack_data_q;

  always_ff @(posedge clk) begin
    ack_data_q <= rd_data_pf;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ack_q <= '0;
      wr_ack_q <= '0;
    end else begin
      rd_ack_q <= rd_vld_pf ? pu_onehot(rd_pu_pf) : '0;
      wr_ack_q <= wr_vld_pf ? pu_onehot(wr_pu_pf) : '0;
    end
  end

  assign io_ack = rd_ack_q | wr_ack_q;

  always_comb begin
    io_ack_data = '0;
    for (int i = 0; i < NUM_OF_PU; i++) begin
      io_ack_data[i] = rd_ack_q[i] ? ack_data_q : '0;
    end
  end

endmodule
